serial_queue_top: RTL and testbench
===================================

Name: serial_queue_top

Overview:
- Top-level serial byte queue clocked from the 1 MHz system clock.
- Assembles 1-bit serial input (data_in qualified by write_in) into bytes and pushes each completed byte into an 8-entry FIFO.
- On a dequeue request, pops one byte and shifts it out serially on data_out, LSB first.
- status_out tells the upstream producer when a bit can be accepted.

Parameters:
- DATA_WIDTH, 8, bits per assembled byte / FIFO word width
- FIFO_DEPTH, 8, number of FIFO entries (power of two)

Ports:
- clock_1MHz  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- data_in  input  1  serial data bit, sampled when write_in=1
- write_in  input  1  bit strobe; one bit is accepted per rising edge with write_in=1 and status_out=1
- enqueue_in  input  1  flush request: close the partially assembled byte and queue it
- dequeue_in  input  1  pop request: remove the oldest byte and serialize it
- status_out  output  1  1 = assembler can accept a bit
- data_out  output  1  serialized output bit

Behaviour:
- Reset (rst=0, asynchronous):
  - bit counter=0, assembly register=0, byte_pending=0.
  - FIFO empty: read pointer, write pointer and count all 0.
  - Serializer idle, data_out=0, status_out=1.
- Assembler:
  - status_out = !byte_pending (combinational).
  - On an edge with write_in=1 and status_out=1: data_in is stored at bit index = counter (first bit becomes bit 0), and the counter increments.
  - write_in while status_out=0: ignored, bit dropped.
  - When the 8th bit is stored: byte_pending=1, so status_out=0 from the next cycle.
  - enqueue_in=1 with counter>0 and byte_pending=0: byte_pending=1. Unfilled upper bits are 0.
  - enqueue_in with counter=0 or byte_pending=1: ignored.
  - write_in and enqueue_in on the same edge: the bit is stored first and is included in the flushed byte.
- Push to FIFO:
  - On any edge with byte_pending=1 and FIFO count<FIFO_DEPTH: write the byte, clear byte_pending, counter=0, assembly register=0.
  - With space available, status_out is therefore low for exactly one cycle per byte.
  - FIFO full: byte_pending holds and status_out stays 0 until a pop frees space. The push then occurs on the edge after the pop.
- Pop and serializer:
  - States: IDLE and SHIFT (3-bit bit index).
  - In IDLE, an edge with dequeue_in=1 and count>0 pops the oldest word into the shift register and moves to SHIFT.
  - In SHIFT, data_out = shift_reg[0] for 8 consecutive cycles, starting the cycle after the pop. The register shifts right each edge.
  - After the 8th bit: return to IDLE, data_out=0.
  - dequeue_in while in SHIFT or with the FIFO empty: ignored, no pop, no error.
  - dequeue_in is level-sampled; holding it high pops again as soon as the serializer returns to IDLE.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge are both performed, count unchanged.
  - Push is never accepted when count=FIFO_DEPTH at the edge.
- Reset mid-operation: all of the above is cleared immediately. Pending and partial bytes and in-flight serialization are lost.

Decomposition:
- Shared package serial_queue_pkg holds:
  - DATA_WIDTH and FIFO_DEPTH defaults
  - the serializer state enum (IDLE, SHIFT)
  - the derived pointer width, $clog2(FIFO_DEPTH)
- One sub-module, byte_fifo: synchronous FIFO with push/pop/full/empty/count, same clock and async active-low reset.
- Assembler and serializer stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> status_out=1, data_out=0. Release -> no change.
- Assemble and queue: send bits 0,1,0,1,0,1,0,1 (one write_in cycle each, waiting for status_out=1) -> status_out low one cycle after the 8th bit; FIFO count=1 holding 8'hAA. Then dequeue_in pulse -> data_out = 0,1,0,1,0,1,0,1 over the next 8 cycles, then 0.
- Flush partial: send bits 1,1,1, then enqueue_in pulse -> FIFO holds 8'h07. Dequeue -> data_out = 1,1,1,0,0,0,0,0.
- Full FIFO: queue 8 bytes, then write 8 more bits -> status_out stays 0 after the 9th byte completes. One dequeue -> the pending byte is pushed on the edge after the pop, status_out returns to 1, and FIFO order is preserved with pointer wrap.
- Ignored requests: dequeue_in with the FIFO empty -> data_out stays 0. dequeue_in during SHIFT -> no extra pop, FIFO count unchanged. write_in while status_out=0 -> bit dropped.
- Async reset mid-serialization: assert rst=0 between clock edges during SHIFT -> data_out=0 immediately, FIFO empty, status_out=1.

Source files
------------

// File: rtl/serial_queue_pkg.sv
// Shared types and default sizing for the serial byte queue.
package serial_queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_PTR_W      = $clog2(DEFAULT_FIFO_DEPTH);

  // Serializer states: waiting for a pop, or streaming a word out LSB first
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/serial_queue_byte_fifo.sv
// Circular-buffer FIFO of assembled bytes. Pointers wrap naturally because the
// depth is a power of two. The storage is tiny, so the oldest word is
// presented combinationally and the consumer registers it on pop.
module byte_fifo
  import serial_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  // Full/empty come straight from the occupancy count; a push is refused when
  // full even if a pop happens on the same edge.
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage write; no reset so the array maps onto RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/serial_queue_top.sv
// Serial byte queue: collects strobed bits into bytes, queues them in a FIFO
// and streams popped bytes back out LSB first.
module serial_queue_top
  import serial_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic clock_1MHz,
  input  logic rst,
  input  logic data_in,
  input  logic write_in,
  input  logic enqueue_in,
  input  logic dequeue_in,
  output logic status_out,
  output logic data_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  // Assembler state
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [DATA_WIDTH-1:0] asm_reg;
  logic [DATA_WIDTH-1:0] asm_next;
  logic                  byte_pending_reg;
  logic                  bit_accept;
  logic                  flush;
  logic                  push_ok;

  // Serializer state
  ser_state_t            state_reg;
  ser_state_t            state_next;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic [IDX_W-1:0]      bit_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  pop_req;

  // FIFO interface
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign status_out = !byte_pending_reg;
  assign bit_accept = write_in && !byte_pending_reg;
  // Counter after this edge's bit, so a same-edge write is included in a flush
  assign bit_cnt_next = bit_cnt_reg + CNT_W'(bit_accept);
  assign flush      = enqueue_in && !byte_pending_reg && (bit_cnt_next != '0);
  assign push_ok    = byte_pending_reg && !fifo_full;

  // Per-bit write enables: the incoming bit lands at the current counter position
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_asm_bit
      assign asm_next[gi] = (bit_accept && (bit_cnt_reg == CNT_W'(gi))) ? data_in : asm_reg[gi];
    end
  endgenerate

  // Assembler: collect bits, mark the byte pending when full or flushed, clear on push
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg      <= '0;
      asm_reg          <= '0;
      byte_pending_reg <= 1'b0;
    end else if (push_ok) begin
      bit_cnt_reg      <= '0;
      asm_reg          <= '0;
      byte_pending_reg <= 1'b0;
    end else begin
      asm_reg     <= asm_next;
      bit_cnt_reg <= bit_cnt_next;
      if ((bit_accept && (bit_cnt_reg == LAST_CNT)) || flush) begin
        byte_pending_reg <= 1'b1;
      end
    end
  end

  byte_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clock_1MHz),
    .rst_n  (rst),
    .push   (push_ok),
    .wr_data(asm_reg),
    .pop    (pop_req),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Serializer state register
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  // Serializer next-state: pop in IDLE when data exists, then shift out one bit per cycle
  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop_req      = 1'b0;
    data_out     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dequeue_in && !fifo_empty) begin
          pop_req      = 1'b1;
          shift_next   = fifo_rd_data;
          bit_idx_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        data_out     = shift_reg[0];
        shift_next   = shift_reg >> 1;
        bit_idx_next = bit_idx_reg + 1'b1;
        if (bit_idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_queue_top.sv
`timescale 1ns/1ps
module tb_serial_queue_top;

  logic clock_1MHz = 1'b0;
  logic rst        = 1'b1;
  logic data_in    = 1'b0;
  logic write_in   = 1'b0;
  logic enqueue_in = 1'b0;
  logic dequeue_in = 1'b0;
  logic status_out;
  logic data_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] full_tbl [8] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hC3};

  serial_queue_top dut (
    .clock_1MHz(clock_1MHz),
    .rst       (rst),
    .data_in   (data_in),
    .write_in  (write_in),
    .enqueue_in(enqueue_in),
    .dequeue_in(dequeue_in),
    .status_out(status_out),
    .data_out  (data_out)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_1MHz);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    while (status_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("status_wait", 32'(status_out), 32'd1);
    data_in  = b;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic pop_start();
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
  endtask

  // Expects the cycle right after a pop; checks 8 bits LSB first, then idle 0.
  task automatic shift_out(input logic [7:0] exp, input logic dq_mid);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("data_out_%02h_b%0d", exp, i), 32'(data_out), 32'(exp[i]));
      dequeue_in = dq_mid && (i < 6);
      tick();
    end
    dequeue_in = 1'b0;
    check("data_out_idle", 32'(data_out), 32'd0);
  endtask

  function automatic logic [31:0] fifo_count();
    return 32'(dut.u_fifo.count_reg);
  endfunction

  initial begin
    // Reset
    #10 rst = 1'b0;
    #1;
    check("rst_status", 32'(status_out), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_status", 32'(status_out), 32'd1);
    check("post_rst_data_out", 32'(data_out), 32'd0);
    check("post_rst_count", fifo_count(), 32'd0);
    $display("txn reset done");

    // Full byte 0,1,0,1,0,1,0,1 -> 8'hAA
    send_byte(8'hAA);
    check("aa_status_low", 32'(status_out), 32'd0);
    tick();
    check("aa_status_back", 32'(status_out), 32'd1);
    check("aa_count", fifo_count(), 32'd1);
    pop_start();
    check("aa_count_after_pop", fifo_count(), 32'd0);
    shift_out(8'hAA, 1'b0);
    $display("txn byte 8'hAA queued and serialized");

    // Dequeue with FIFO empty is ignored
    dequeue_in = 1'b1;
    tick();
    tick();
    dequeue_in = 1'b0;
    check("empty_deq_data_out", 32'(data_out), 32'd0);
    check("empty_deq_count", fifo_count(), 32'd0);
    $display("txn dequeue on empty ignored");

    // Enqueue with nothing assembled is ignored
    enqueue_in = 1'b1;
    tick();
    enqueue_in = 1'b0;
    check("empty_enq_status", 32'(status_out), 32'd1);
    tick();
    check("empty_enq_count", fifo_count(), 32'd0);
    $display("txn enqueue with no bits ignored");

    // Partial flush 1,1,1 -> 8'h07
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    enqueue_in = 1'b1;
    tick();
    enqueue_in = 1'b0;
    check("flush_status_low", 32'(status_out), 32'd0);
    tick();
    check("flush_count", fifo_count(), 32'd1);
    pop_start();
    shift_out(8'h07, 1'b0);
    $display("txn partial flush 8'h07");

    // Write and enqueue on the same edge: 1,0 then 1+flush -> 8'h05
    send_bit(1'b1);
    send_bit(1'b0);
    data_in    = 1'b1;
    write_in   = 1'b1;
    enqueue_in = 1'b1;
    tick();
    data_in    = 1'b0;
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    check("same_edge_status", 32'(status_out), 32'd0);
    tick();
    check("same_edge_count", fifo_count(), 32'd1);
    pop_start();
    shift_out(8'h05, 1'b0);
    $display("txn write+enqueue same edge 8'h05");

    // Fill the FIFO, then a 9th byte stalls as pending
    for (int k = 0; k < 8; k++) send_byte(full_tbl[k]);
    tick();
    check("full_count", fifo_count(), 32'd8);
    check("full_status", 32'(status_out), 32'd1);
    send_byte(8'h96);
    check("ninth_status_low", 32'(status_out), 32'd0);
    data_in  = 1'b1;
    write_in = 1'b1;
    tick();
    tick();
    write_in = 1'b0;
    data_in  = 1'b0;
    check("stalled_status", 32'(status_out), 32'd0);
    check("stalled_count", fifo_count(), 32'd8);
    pop_start();
    check("pop_edge_status", 32'(status_out), 32'd0);
    check("pop_edge_count", fifo_count(), 32'd7);
    shift_out(full_tbl[0], 1'b0);
    check("push_after_pop_status", 32'(status_out), 32'd1);
    check("push_after_pop_count", fifo_count(), 32'd8);
    $display("txn full FIFO stall and release");

    // Dequeue held during SHIFT must not pop again
    pop_start();
    shift_out(full_tbl[1], 1'b1);
    check("deq_in_shift_count", fifo_count(), 32'd7);
    $display("txn dequeue during shift ignored");

    // Drain: order preserved across pointer wrap
    for (int k = 2; k < 8; k++) begin
      pop_start();
      shift_out(full_tbl[k], 1'b0);
    end
    pop_start();
    shift_out(8'h96, 1'b0);
    check("drained_count", fifo_count(), 32'd0);
    $display("txn drain in order with wrap");

    // Asynchronous reset during serialization
    send_byte(8'hFF);
    tick();
    pop_start();
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_data_out", 32'(data_out), 32'd1);
    #200 rst = 1'b0;
    #1;
    check("async_rst_data_out", 32'(data_out), 32'd0);
    check("async_rst_status", 32'(status_out), 32'd1);
    check("async_rst_count", fifo_count(), 32'd0);
    check("async_rst_bit_cnt", 32'(dut.bit_cnt_reg), 32'd0);
    @(negedge clock_1MHz);
    rst = 1'b1;
    tick();
    pop_start();
    check("after_rst_deq_data_out", 32'(data_out), 32'd0);
    $display("txn async reset mid-shift");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #20ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
